// File: rtl/gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gate_pkg
// Description : Shared types and the gate reference function for the
//               basic_gates truth-table checker.
//               gate_op_e     - gate selector (AND..BUF).
//               chk_state_e   - checker FSM state encoding.
//               gate_expected - expected gate output for a vector.
// Revision    : 1.0 - initial release
// ============================================================================
package gate_pkg;

    // Widest vector the reference function accepts.
    localparam int unsigned C_MAX_IN = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } gate_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } chk_state_e;

    // Reductions cover only the low n_in bits; bits above n_in are ignored
    // so the same function serves every vector width.
    function automatic logic gate_expected(
        input gate_op_e              op,
        input logic [C_MAX_IN-1:0]   vec,
        input int unsigned           n_in
    );
        logic w_all_ones;
        logic w_any_one;
        logic w_parity;
        logic w_result;
        w_all_ones = 1'b1;
        w_any_one  = 1'b0;
        w_parity   = 1'b0;
        for (int unsigned i = 0; i < C_MAX_IN; i++) begin
            if (i < n_in) begin
                w_all_ones = w_all_ones & vec[i];
                w_any_one  = w_any_one  | vec[i];
                w_parity   = w_parity   ^ vec[i];
            end
        end
        case (op)
            OP_AND:  w_result = w_all_ones;
            OP_OR:   w_result = w_any_one;
            OP_NAND: w_result = ~w_all_ones;
            OP_NOR:  w_result = ~w_any_one;
            OP_XOR:  w_result = w_parity;
            OP_XNOR: w_result = ~w_parity;
            OP_NOT:  w_result = ~vec[0];
            OP_BUF:  w_result = vec[0];
            default: w_result = 1'b0;
        endcase
        return w_result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gate_ref_model
// Description : Combinational reference for one basic gate.
//               op       in  gate selector
//               vec      in  N_IN-bit input vector (vec[0] = input a)
//               expected out expected gate output
// Revision    : 1.0 - initial release
// ============================================================================
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  gate_op_e          op,
    input  logic [N_IN-1:0]   vec,
    output logic              expected
);

    logic [C_MAX_IN-1:0] w_vec_ext;

    always_comb begin
        w_vec_ext             = '0;
        w_vec_ext[N_IN-1:0]   = vec;
        expected              = gate_expected(op, w_vec_ext, N_IN);
    end

endmodule
`default_nettype wire

// File: rtl/gate_truth_table_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_truth_table_checker
// Description : Sweeps every input vector into a basic gate, waits for the
//               gate to settle, and compares its output with the reference.
//               clk            in  clock, rising edge
//               rst            in  synchronous active-high reset
//               start          in  begin a sweep (honoured only when idle/done)
//               op_sel         in  gate under test, latched on accepted start
//               dut_y          in  gate output being checked
//               vec            out vector driven into the gate
//               busy           out sweep in progress
//               done           out sweep finished (level until next start)
//               pass           out no mismatches (valid with done)
//               err_count      out mismatching vectors this sweep
//               first_fail_vld out at least one mismatch this sweep
//               first_fail_vec out vector of the first mismatch
// Revision    : 1.0 - initial release
// ============================================================================
module gate_truth_table_checker
    import gate_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op_sel,
    input  logic              dut_y,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              first_fail_vld,
    output logic [N_IN-1:0]   first_fail_vec
);

    localparam int C_CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int C_ERR_W = N_IN + 1;

    chk_state_e           r_state;
    chk_state_e           w_next_state;
    gate_op_e             r_op;
    logic [N_IN-1:0]      r_vec;
    logic [C_CNT_W-1:0]   r_cnt;
    logic [C_ERR_W-1:0]   r_err;
    logic                 r_ffv;
    logic [N_IN-1:0]      r_ffvec;

    logic                 w_expected;
    logic                 w_mismatch;
    logic                 w_accept;
    logic                 w_last_vec;

    gate_ref_model #(
        .N_IN     (N_IN)
    ) u_ref (
        .op       (r_op),
        .vec      (r_vec),
        .expected (w_expected)
    );

    // Case inequality so an undriven or X gate output counts as a failure
    // in simulation.
    assign w_mismatch = (dut_y !== w_expected);
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last_vec = &r_vec;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_accept) begin
                    w_next_state = ST_DRIVE;
                end
            end
            ST_DRIVE:  w_next_state = ST_SETTLE;
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_SAMPLE;
                end
            end
            ST_SAMPLE: w_next_state = w_last_vec ? ST_DONE : ST_DRIVE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Vector counter, settle counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_AND;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_accept) begin
                        r_op    <= gate_op_e'(op_sel);
                        r_vec   <= '0;
                        r_err   <= '0;
                        r_ffv   <= 1'b0;
                        r_ffvec <= '0;
                    end
                end
                ST_DRIVE: begin
                    // SETTLE lasts SETTLE_CYC cycles including the terminal 0.
                    r_cnt <= C_CNT_W'(SETTLE_CYC - 1);
                end
                ST_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (w_mismatch) begin
                        // Width N_IN+1 holds 2**N_IN, so this never wraps.
                        r_err <= r_err + C_ERR_W'(1);
                        if (!r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= r_vec;
                        end
                    end
                    // The final vector stays on vec after the sweep ends.
                    if (!w_last_vec) begin
                        r_vec <= r_vec + N_IN'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vec            = r_vec;
    assign busy           = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) ||
                            (r_state == ST_SAMPLE);
    assign done           = (r_state == ST_DONE);
    assign pass           = done && (r_err == '0);
    assign err_count      = r_err;
    assign first_fail_vld = r_ffv;
    assign first_fail_vec = r_ffvec;

endmodule
`default_nettype wire
